fq_bw_ctrl: RTL
===============

Name: fq_bw_ctrl

Overview:
- Parametrised bandwidth/latency timestamp controller for one flow queue (FQ). One instance per FQ.
- Assigns each accepted flit a departure timestamp. At most `bandwidth` flits share one timestamp slot. Configured latency is added to the slot.
- Adds over the previous generation:
  - parametrised widths;
  - wrap-aware timestamp comparison;
  - correct slot bumping on older timestamps;
  - unlimited-bandwidth mode;
  - idle expiry back to the IDLE state.
- Sits between the FQ input arbitration and the timestamp field of the outgoing flit. Configuration is daisy-chained.

Parameters:
- TS_WIDTH, 10, timestamp / sim_time width.
- BW_WIDTH, 8, bandwidth and count width (flits per slot).
- LAT_WIDTH, 8, latency width in timestamp units.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- sim_time  in  TS_WIDTH  current simulation time.
- sim_time_tick  in  1  sim_time advanced this cycle.
- in_ready  in  1  flit accepted this cycle.
- in_timestamp  in  TS_WIDTH  flit arrival timestamp.
- out_valid  out  1  equals in_ready (combinational).
- out_timestamp  out  TS_WIDTH  departure timestamp (combinational, same cycle as in_ready).
- busy  out  1  high when the state is COUNT.
- config_in_valid  in  1  config shift enable.
- config_in  in  BW_WIDTH+LAT_WIDTH  {bandwidth, latency}.
- config_out_valid  out  1  equals config_in_valid (combinational).
- config_out  out  BW_WIDTH+LAT_WIDTH  current {bandwidth, latency} register value.

Behaviour:
- Interface: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values:
  - bandwidth, latency, count, last_ts and expire_ts are all 0.
  - State is IDLE; busy is 0.
  - out_valid follows in_ready.
  - With in_ready=0, out_timestamp = last_ts + latency (0 after reset).
- Config register:
  - Loads config_in on the clock edge when config_in_valid=1.
  - A new value applies from the next cycle.
  - count is not cleared by a config load.
- Newer test: newer = in_timestamp != last_ts, and MSB of (in_timestamp - last_ts) mod 2^TS_WIDTH is 0. This is a wrap-aware signed comparison.
- Full test: full = (bandwidth != 0) and (count >= bandwidth). bandwidth=0 means unlimited, so full is never true.
- Slot selection when in_ready=1:
  - IDLE: slot = in_timestamp; count <= 1; state <= COUNT.
  - COUNT and newer: slot = in_timestamp; count <= 1.
  - COUNT, not newer, full: slot = last_ts + 1; count <= 1.
  - COUNT, not newer, not full: slot = last_ts; count <= count + 1, saturating at all-ones.
- On every in_ready=1 cycle:
  - out_timestamp = slot + latency, mod 2^TS_WIDTH, with latency zero-extended or truncated to TS_WIDTH.
  - last_ts <= slot.
  - expire_ts <= slot + 1.
- Idle expiry: in COUNT with in_ready=0, sim_time_tick=1 and sim_time == expire_ts:
  - state <= IDLE; count <= 0.
  - last_ts is kept.
- Simultaneous in_ready and expiry condition: in_ready wins. State stays COUNT.
- Reset mid-operation: everything returns to reset values on the next edge. An in_ready during the reset cycle is ignored for state updates.
- Latency: in_ready to out_timestamp is 0 cycles (combinational). State updates take effect at the next edge.

Optional Feature:
- Macro: FQ_BW_STATS_EN.
- Enabled:
  - Adds output port stat_bump_count, 16 bits.
  - It is a saturating counter of acceptances that took the "not newer, full" branch.
  - Cleared by reset.
- Disabled: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Config bw=2, lat=3. in_ready for 4 cycles with ts=5 → out_timestamp 8, 8, 9, 9; busy=1 after the first edge.
2. Continuing case 1: in ts=20 → out 23; next ts=20 → out 23; third ts=20 → out 24.
3. Wrap: last_ts=1022, in ts=1 → newer, out=1+lat. Then in ts=1020 → not newer, slot=1 (or 2 if full).
4. Expiry: accept slot=10, idle, sim_time=11 with tick → busy=0 next cycle. Repeat with in_ready=1 in the tick cycle → busy stays 1.
5. bw=0, lat=0: 5 consecutive flits with ts=7 → all out 7. With FQ_BW_STATS_EN, stat_bump_count stays 0. Repeat with bw=1 → outs 7, 8, 9, 10, 11 and stat_bump_count=4.
6. Reset asserted mid-COUNT with in_ready=1 → next cycle busy=0, config_out=0, out_timestamp = in_timestamp for the next first flit.

Source files
------------

// File: rtl/fq_bw_ctrl.sv
// fq_bw_ctrl
//   Bandwidth/latency timestamp controller for a single flow queue.
//   Every accepted flit gets a departure timestamp: at most `bandwidth`
//   flits share one timestamp slot, and the configured latency is added
//   to that slot. A bandwidth of 0 means unlimited. The controller falls
//   back to IDLE when sim_time reaches the slot after the last one used
//   and no flit arrives in that cycle.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   sim_time/_tick        current simulation time and its advance strobe
//   in_ready/in_timestamp flit accepted this cycle and its arrival time
//   out_valid/out_timestamp  combinational departure timestamp
//   busy                  high while in COUNT
//   config_in_valid/config_in   daisy-chained {bandwidth, latency} load
//   config_out_valid/config_out current configuration, passed down chain
//   stat_bump_count       (FQ_BW_STATS_EN only) saturating count of
//                         flits pushed to the next slot because the
//                         current one was full
//
// Build option: define FQ_BW_STATS_EN to add stat_bump_count.

module fq_bw_ctrl #(
    parameter int unsigned TS_WIDTH  = 10,
    parameter int unsigned BW_WIDTH  = 8,
    parameter int unsigned LAT_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [TS_WIDTH-1:0]           sim_time,
    input  logic                          sim_time_tick,
    input  logic                          in_ready,
    input  logic [TS_WIDTH-1:0]           in_timestamp,
    output logic                          out_valid,
    output logic [TS_WIDTH-1:0]           out_timestamp,
    output logic                          busy,
    input  logic                          config_in_valid,
    input  logic [BW_WIDTH+LAT_WIDTH-1:0] config_in,
    output logic                          config_out_valid,
    output logic [BW_WIDTH+LAT_WIDTH-1:0] config_out
`ifdef FQ_BW_STATS_EN
    ,
    output logic [15:0]                   stat_bump_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [TS_WIDTH-1:0] TS_ONE  = TS_WIDTH'(1);
    localparam logic [BW_WIDTH-1:0] CNT_ONE = BW_WIDTH'(1);

    state_t                r_state;
    logic [BW_WIDTH-1:0]   r_bw;
    logic [LAT_WIDTH-1:0]  r_lat;
    logic [BW_WIDTH-1:0]   r_count;
    logic [TS_WIDTH-1:0]   r_last_ts;
    logic [TS_WIDTH-1:0]   r_expire_ts;

    state_t                w_state_nxt;
    logic [BW_WIDTH-1:0]   w_count_nxt;
    logic [TS_WIDTH-1:0]   w_slot;
    logic [TS_WIDTH-1:0]   w_diff;
    logic [TS_WIDTH-1:0]   w_lat_ts;
    logic                  w_newer;
    logic                  w_full;
    logic                  w_bump;

    // Latency is zero-extended or truncated into the timestamp domain.
    generate
        if (LAT_WIDTH >= TS_WIDTH) begin : g_lat_trunc
            assign w_lat_ts = r_lat[TS_WIDTH-1:0];
        end else begin : g_lat_ext
            assign w_lat_ts = {{(TS_WIDTH-LAT_WIDTH){1'b0}}, r_lat};
        end
    endgenerate

    // Wrap-aware ordering: in_timestamp is newer when it lies in the half
    // of the modular circle ahead of last_ts.
    assign w_diff  = in_timestamp - r_last_ts;
    assign w_newer = (in_timestamp != r_last_ts) && !w_diff[TS_WIDTH-1];
    assign w_full  = (r_bw != '0) && (r_count >= r_bw);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_slot      = r_last_ts;
        w_bump      = 1'b0;
        if (in_ready) begin
            if (r_state == IDLE) begin
                w_slot      = in_timestamp;
                w_count_nxt = CNT_ONE;
                w_state_nxt = COUNT;
            end else if (w_newer) begin
                w_slot      = in_timestamp;
                w_count_nxt = CNT_ONE;
            end else if (w_full) begin
                w_slot      = r_last_ts + TS_ONE;
                w_count_nxt = CNT_ONE;
                w_bump      = 1'b1;
            end else if (r_count != '1) begin
                w_count_nxt = r_count + CNT_ONE;
            end
        end else if ((r_state == COUNT) && sim_time_tick &&
                     (sim_time == r_expire_ts)) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bw        <= '0;
            r_lat       <= '0;
            r_count     <= '0;
            r_last_ts   <= '0;
            r_expire_ts <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (in_ready) begin
                r_last_ts   <= w_slot;
                r_expire_ts <= w_slot + TS_ONE;
            end
            if (config_in_valid) begin
                {r_bw, r_lat} <= config_in;
            end
        end
    end

`ifdef FQ_BW_STATS_EN
    logic [15:0] r_bump_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bump_count <= '0;
        end else if (w_bump && (r_bump_count != '1)) begin
            r_bump_count <= r_bump_count + 16'd1;
        end
    end

    assign stat_bump_count = r_bump_count;
`endif

    assign out_valid        = in_ready;
    assign out_timestamp    = w_slot + w_lat_ts;
    assign busy             = (r_state == COUNT);
    assign config_out_valid = config_in_valid;
    assign config_out       = {r_bw, r_lat};

endmodule
